// File: rtl/chunked_add_seq.sv
// Multi-cycle wide adder built on an external CHUNK_W-bit fulladd.
// Operands are latched on accept and added one chunk per cycle, LS chunk first.
module chunked_add_seq #(
    parameter  int CHUNK_W    = 3,
    parameter  int NUM_CHUNKS = 4,
    localparam int OP_W       = CHUNK_W * NUM_CHUNKS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     in_a,
    input  logic [OP_W-1:0]     in_b,
    input  logic                in_cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OP_W-1:0]     out_sum,
    output logic                out_cout,
    output logic                busy,
    output logic [CHUNK_W-1:0]  add_a,
    output logic [CHUNK_W-1:0]  add_b,
    output logic                add_cin,
    input  logic [CHUNK_W-1:0]  add_sum,
    input  logic                add_cout
);

    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [OP_W-1:0] CHUNK_MASK = OP_W'({CHUNK_W{1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  idx;
    logic [OP_W-1:0]   a_reg, b_reg, sum_reg;
    logic [OP_W-1:0]   a_shifted, b_shifted, sum_upd;
    logic              cin_reg, carry_reg;
    logic              last_chunk;
    int unsigned       chunk_shift;

    // Next state, handshake decode and the chunk slice fed to the adder.
    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        add_a       = '0;
        add_b       = '0;
        add_cin     = 1'b0;
        last_chunk  = (idx == IDX_W'(NUM_CHUNKS - 1));
        chunk_shift = 32'(idx) * CHUNK_W;
        a_shifted   = a_reg >> chunk_shift;
        b_shifted   = b_reg >> chunk_shift;
        sum_upd     = (sum_reg & ~(CHUNK_MASK << chunk_shift))
                    | (OP_W'(add_sum) << chunk_shift);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = a_shifted[CHUNK_W-1:0];
                add_b   = b_shifted[CHUNK_W-1:0];
                add_cin = (idx == '0) ? cin_reg : carry_reg;
                if (last_chunk) state_next = DONE;
            end
            DONE: begin
                busy = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus operand latch, partial-sum/carry capture and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            cin_reg   <= 1'b0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= in_a;
                        b_reg   <= in_b;
                        cin_reg <= in_cin;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_upd;
                    carry_reg <= add_cout;
                    // The result register only changes when a full sum is ready.
                    if (last_chunk) begin
                        out_sum   <= sum_upd;
                        out_cout  <= add_cout;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_add_seq.sv
// Scoreboard bench for chunked_add_seq with a behavioural fulladd attached.
// Expected results come from plain wide addition of the accepted operands.
module tb_chunked_add_seq;

    localparam int CHUNK_W    = 3;
    localparam int NUM_CHUNKS = 4;
    localparam int OP_W       = CHUNK_W * NUM_CHUNKS;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready, in_cin;
    logic [OP_W-1:0]    in_a, in_b;
    logic               out_valid, out_ready, out_cout;
    logic [OP_W-1:0]    out_sum;
    logic               busy;
    logic [CHUNK_W-1:0] add_a, add_b, add_sum;
    logic               add_cin, add_cout;

    int checkCount = 0;
    int passCount  = 0;
    bit randomReady = 1'b0;
    logic [OP_W:0] expQ[$];

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = 4'(add_a) + 4'(add_b) + 4'(add_cin);

    chunked_add_seq #(.CHUNK_W(CHUNK_W), .NUM_CHUNKS(NUM_CHUNKS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    function automatic logic [OP_W:0] model(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                            input logic cin);
        return (OP_W+1)'(a) + (OP_W+1)'(b) + (OP_W+1)'(cin);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Offer one operand pair and push its expected result when it is taken.
    task automatic applyStimulus(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                 input logic cin, output int waited);
        bit accepted = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        waited = 0;
        while (!accepted && waited < 100) begin
            @(negedge clk);
            waited++;
            if (in_ready) begin
                expQ.push_back(model(a, b, cin));
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            if (randomReady) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        in_a = OP_W'($urandom);
        in_b = OP_W'($urandom);
        in_cin = 1'($urandom);
        if (!accepted) checkOutput("accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic waitIdle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) checkOutput("idle_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer is compared with the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_result: got %0h, expected none", {out_cout, out_sum});
            end else begin
                checkOutput("result", 32'({out_cout, out_sum}), 32'(expQ.pop_front()));
            end
        end
    end

    initial begin
        int waited;
        logic [OP_W:0] bpExp;

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
        checkOutput("rst_out_cout", 32'(out_cout), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_add_bus", 32'({add_a, add_b, add_cin}), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        // Latency: valid must rise exactly after the fourth edge following accept.
        applyStimulus(12'h001, 12'h000, 1'b0, waited);
        repeat (4) @(negedge clk);
        checkOutput("lat_not_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_valid", 32'(out_valid), 32'd1);
        checkOutput("lat_busy", 32'(busy), 32'd1);
        waitIdle();

        applyStimulus(12'h003, 12'h007, 1'b0, waited);
        waitIdle();

        // Carry must propagate through every upper chunk.
        applyStimulus(12'hFFF, 12'h001, 1'b0, waited);
        @(negedge clk);
        checkOutput("c0_add_a", 32'(add_a), 32'd7);
        checkOutput("c0_add_b", 32'(add_b), 32'd1);
        checkOutput("c0_add_cin", 32'(add_cin), 32'd0);
        for (int k = 1; k < NUM_CHUNKS; k++) begin
            @(negedge clk);
            checkOutput($sformatf("c%0d_add_cin", k), 32'(add_cin), 32'd1);
        end
        waitIdle();

        applyStimulus(12'hFFF, 12'hFFF, 1'b1, waited);
        waitIdle();

        // Backpressure in DONE with a new operand pair pending.
        out_ready = 1'b0;
        applyStimulus(12'h5A5, 12'h3C3, 1'b0, waited);
        bpExp = model(12'h5A5, 12'h3C3, 1'b0);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!out_valid && waited < 20);
        in_valid = 1'b1;
        in_a = 12'h0F0;
        in_b = 12'h00F;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_out_sum", 32'(out_sum), 32'(bpExp[OP_W-1:0]));
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(12'h123, 12'h456, 1'b1, waited);
        checkOutput("bp_accept_delay", 32'(waited), 32'd2);
        waitIdle();

        // Reset while RUN is on chunk 2 discards the operation.
        applyStimulus(12'h0AB, 12'h0CD, 1'b0, waited);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_add_bus", 32'({add_a, add_b, add_cin}), 32'd0);
        void'(expQ.pop_back());
        rst = 1'b0;
        applyStimulus(12'h005, 12'h001, 1'b0, waited);
        waitIdle();

        // Random operands with random consumer backpressure.
        randomReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(OP_W'($urandom), OP_W'($urandom), 1'($urandom), waited);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        randomReady = 1'b0;
        out_ready = 1'b1;
        waited = 0;
        while (expQ.size() != 0 && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
